rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Arbiter and sequencer for the single write port of the 32x32 register file. It merges two writeback sources: the in-order pipeline writeback (A) and a multi-cycle unit such as mul/div (B). B is buffered in a 2-entry FIFO, and one registered write per cycle is driven to the register file. It also exports a pending-destination mask so hazard logic can stall readers of registers with a queued B write.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles a non-empty B FIFO may lose to A before B is forced through (range 1..15).
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous and active-high.
- a_valid  input  1  pipeline writeback request this cycle.
- a_waddr  input  5  pipeline destination register.
- a_wdata  input  32  pipeline write data.
- a_stall  output  1  A not accepted this cycle; pipeline holds a_valid/a_waddr/a_wdata.
- b_valid  input  1  multi-cycle unit result valid.
- b_ready  output  1  FIFO can accept; transfer when b_valid && b_ready.
- b_waddr  input  5  multi-cycle destination register.
- b_wdata  input  32  multi-cycle result.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- busy_mask  output  32  bit i set while a FIFO entry targets register i (bit 0 always 0).

## Operation
- B FIFO: 2 entries, head/tail pointers, 2-bit count. b_ready = (count != 2), with no pass-through when full. Push on b_valid && b_ready. Pop when the head is granted. Push and pop in the same cycle leave count unchanged.
- FSM states:
  - PRIO_A (reset state): A wins whenever a_valid. The head is granted only when !a_valid && count != 0.
  - FORCE_B: the head is granted and a_stall = a_valid.
- Transitions:
  - PRIO_A -> FORCE_B when count != 0, the head was not granted, and starve_cnt == STARVE_LIMIT-1 (the starve_cnt increment is replaced by the transition).
  - FORCE_B -> PRIO_A unconditionally after one grant.
- starve_cnt (4-bit):
  - Increments in PRIO_A when count != 0 and the head is not granted.
  - Clears on any head grant or when count == 0.
- a_stall is 0 in PRIO_A and is combinational from the state and a_valid.
- Winner is latched into rf_we/rf_waddr/rf_wdata on the next posedge. No winner gives rf_we = 0, with addr/data holding their last values.
- Register 0:
  - A request or FIFO head with waddr == 0 is still granted and consumed, but rf_we stays 0 for that cycle.
  - A push with b_waddr == 0 is accepted normally.
- busy_mask = OR of one-hot(waddr) over valid FIFO entries, masked bit 0. It is combinational from FIFO state; the bit clears in the cycle after the entry pops.
- A and the head targeting the same register: grant order defines the final value; no merging.

## Timing
- Reset values: rf_we 0, rf_waddr 0, rf_wdata 0, FIFO empty, b_ready 1, busy_mask 0, a_stall 0, FSM PRIO_A, starve_cnt 0.
- A latency: a_valid accepted in cycle n gives rf_we in cycle n+1.
- B latency: push in cycle n, earliest grant in n+1, rf_we in n+2.
- Reset asserted mid-operation discards FIFO contents and any pending grant immediately (asynchronously). The first push is possible in the first cycle after deassertion.
- Throughput: one write per cycle. B sustains one every cycle when A is idle.

## Configuration
- RF_WRITE_ARB_STARVE_EN:
  - Defined: FORCE_B state and starve_cnt are implemented as above.
  - Undefined: the FSM is permanently PRIO_A, starve_cnt is removed, a_stall is tied 0, and B is strict low priority (B may starve under continuous A traffic).

## Structure
- Shared package: REG_ADDR_W = 5, REG_DATA_W = 32, NUM_REGS = 32, the FSM state enum (PRIO_A, FORCE_B), and the FIFO entry typedef {waddr, wdata}.
- One natural sub-module: rf_wb_fifo (2-entry FIFO exposing count, head, and per-entry valid/waddr for busy_mask).

## Test plan
- Reset check: assert rst mid-stream with 2 B entries queued -> rf_we = 0, b_ready = 1, busy_mask = 0 immediately; no queued write appears after release.
- A only: a_valid with waddr = 5, wdata = 0xDEADBEEF in cycle n -> rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF in cycle n+1.
- B idle path: push waddr = 7, wdata = 0x12345678 at n with A idle -> busy_mask[7] = 1 at n+1, write at n+2, busy_mask[7] = 0 afterwards.
- FIFO full: push 3 consecutive B results under continuous A traffic -> b_ready = 0 after 2 pushes; the third is held until a pop.
- Starvation (macro on, STARVE_LIMIT = 4): continuous a_valid with one B entry -> 4 A writes, then a_stall = 1 for one cycle and B is written; with the macro off, B never writes.
- Register 0: A writes r0 and B writes r0 -> both consumed, rf_we stays 0, busy_mask[0] stays 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional starvation guard is enabled by defining RF_WRITE_ARB_STARVE_EN.
package rf_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    PRIO_A,
    FORCE_B
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// 2-entry writeback FIFO for the multi-cycle unit; exposes per-entry state
// so the top can build the pending-destination mask.
module rf_wb_fifo
  import rf_write_arbiter_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  output logic [1:0]                 o_count,
  output wb_entry_t                  o_head,
  output logic [1:0]                 o_entry_valid,
  output logic [1:0][REG_ADDR_W-1:0] o_entry_waddr
);

  wb_entry_t  r_mem [2];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_tail <= ~r_tail;
      if (i_pop)  r_head <= ~r_head;
      if (i_push && !i_pop)      r_count <= r_count + 2'd1;
      else if (!i_push && i_pop) r_count <= r_count - 2'd1;
    end
  end

  // Payload needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  assign o_count          = r_count;
  assign o_head           = r_mem[r_head];
  assign o_entry_valid[0] = (r_count == 2'd2) || ((r_count == 2'd1) && !r_head);
  assign o_entry_valid[1] = (r_count == 2'd2) || ((r_count == 2'd1) && r_head);
  assign o_entry_waddr[0] = r_mem[0].waddr;
  assign o_entry_waddr[1] = r_mem[1].waddr;

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write-port arbiter: pipeline writeback (A) vs buffered multi-cycle results (B).
// Define RF_WRITE_ARB_STARVE_EN to force B through after STARVE_LIMIT lost cycles.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_valid,
  input  logic [REG_ADDR_W-1:0] i_a_waddr,
  input  logic [REG_DATA_W-1:0] i_a_wdata,
  output logic                  o_a_stall,
  input  logic                  i_b_valid,
  output logic                  o_b_ready,
  input  logic [REG_ADDR_W-1:0] i_b_waddr,
  input  logic [REG_DATA_W-1:0] i_b_wdata,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [REG_DATA_W-1:0] o_rf_wdata,
  output logic [NUM_REGS-1:0]   o_busy_mask
);

  logic [1:0]                 w_count;
  wb_entry_t                  w_head;
  logic [1:0]                 w_entry_valid;
  logic [1:0][REG_ADDR_W-1:0] w_entry_waddr;
  logic                       w_fifo_nempty;
  logic                       w_push;
  logic                       w_grant_a;
  logic                       w_grant_b;
  arb_state_e                 w_state;
  wb_entry_t                  w_win;
  logic                       w_win_we;

  assign w_fifo_nempty = (w_count != 2'd0);
  assign o_b_ready     = (w_count != 2'd2);
  assign w_push        = i_b_valid && o_b_ready;

  rf_wb_fifo u_fifo (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (w_push),
    .i_push_entry  ('{waddr: i_b_waddr, wdata: i_b_wdata}),
    .i_pop         (w_grant_b),
    .o_count       (w_count),
    .o_head        (w_head),
    .o_entry_valid (w_entry_valid),
    .o_entry_waddr (w_entry_waddr)
  );

`ifdef RF_WRITE_ARB_STARVE_EN
  arb_state_e r_state;
  arb_state_e w_state_d;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= PRIO_A;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_d;
      r_starve_cnt <= w_starve_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_starve_d = r_starve_cnt;
    unique case (r_state)
      PRIO_A: begin
        if (!w_fifo_nempty || w_grant_b) begin
          w_starve_d = 4'd0;
        end else if (r_starve_cnt == 4'(STARVE_LIMIT - 1)) begin
          w_state_d = FORCE_B;
        end else begin
          w_starve_d = r_starve_cnt + 4'd1;
        end
      end
      FORCE_B: begin
        w_state_d  = PRIO_A;
        w_starve_d = 4'd0;
      end
      default: w_state_d = PRIO_A;
    endcase
  end

  assign w_state = r_state;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^STARVE_LIMIT;
  assign w_state        = PRIO_A;
`endif

  always_comb begin
    o_a_stall = (w_state == FORCE_B) && i_a_valid;
    w_grant_b = (w_state == FORCE_B) ? w_fifo_nempty : (!i_a_valid && w_fifo_nempty);
    w_grant_a = i_a_valid && !o_a_stall && !w_grant_b;
  end

  // A register-0 winner is consumed but never reaches the register file.
  always_comb begin
    w_win    = w_grant_b ? w_head : '{waddr: i_a_waddr, wdata: i_a_wdata};
    w_win_we = (w_grant_a || w_grant_b) && (w_win.waddr != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_we <= w_win_we;
      if (w_win_we) begin
        o_rf_waddr <= w_win.waddr;
        o_rf_wdata <= w_win.wdata;
      end
    end
  end

  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (w_entry_valid[i]) o_busy_mask = o_busy_mask | addr_onehot(w_entry_waddr[i]);
    end
    o_busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; starvation checks follow RF_WRITE_ARB_STARVE_EN.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_a_valid   (a_valid),
    .i_a_waddr   (a_waddr),
    .i_a_wdata   (a_wdata),
    .o_a_stall   (a_stall),
    .i_b_valid   (b_valid),
    .o_b_ready   (b_ready),
    .i_b_waddr   (b_waddr),
    .i_b_wdata   (b_wdata),
    .o_rf_we     (rf_we),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata),
    .o_busy_mask (busy_mask)
  );

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        br;
    logic [31:0] busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic br, logic [31:0] busy,
                              logic we, logic [4:0] wa, logic [31:0] wd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.br = br; v.busy = busy;
    v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
    check({tag, " rf_we"}, 32'(rf_we), 32'(we));
    check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(wa));
    check({tag, " rf_wdata"}, rf_wdata, wd);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //           A: v  addr  data          B: v  addr  data          rdy busy        we addr data
    vecs[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h0,      0, 5'd0,  32'h0);
    vecs[1]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 32'h0,      1, 5'd5,  32'hDEADBEEF);
    vecs[2]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h12345678, 1, 32'h0,      0, 5'd5,  32'hDEADBEEF);
    vecs[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h80,     1, 5'd7,  32'h12345678);
    vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h0,      0, 5'd7,  32'h12345678);
    vecs[5]  = mk(1, 5'd3,  32'h11111111, 1, 5'd9,  32'hA0A0A0A0, 1, 32'h0,      1, 5'd3,  32'h11111111);
    vecs[6]  = mk(1, 5'd4,  32'h22222222, 1, 5'd10, 32'hB0B0B0B0, 1, 32'h200,    1, 5'd4,  32'h22222222);
    vecs[7]  = mk(1, 5'd6,  32'h33333333, 1, 5'd11, 32'hC0C0C0C0, 0, 32'h600,    1, 5'd6,  32'h33333333);
    vecs[8]  = mk(0, 5'd0,  32'h0,        1, 5'd11, 32'hC0C0C0C0, 0, 32'h600,    1, 5'd9,  32'hA0A0A0A0);
    vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd11, 32'hC0C0C0C0, 1, 32'h400,    1, 5'd10, 32'hB0B0B0B0);
    vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h800,    1, 5'd11, 32'hC0C0C0C0);
    vecs[11] = mk(1, 5'd0,  32'h55555555, 0, 5'd0,  32'h0,        1, 32'h0,      0, 5'd11, 32'hC0C0C0C0);
    vecs[12] = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h66666666, 1, 32'h0,      0, 5'd11, 32'hC0C0C0C0);
    vecs[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h0,      0, 5'd11, 32'hC0C0C0C0);
    vecs[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h0,      0, 5'd11, 32'hC0C0C0C0);
    vecs[15] = mk(0, 5'd0,  32'h0,        1, 5'd12, 32'h77777777, 1, 32'h0,      0, 5'd11, 32'hC0C0C0C0);
    vecs[16] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 32'h1000,   1, 5'd12, 32'h77777777);

    repeat (2) @(negedge clk);
    check("reset b_ready", 32'(b_ready), 32'd1);
    check("reset busy_mask", busy_mask, 32'h0);
    check("reset a_stall", 32'(a_stall), 32'd0);
    check_rf("reset", 1'b0, 5'd0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      #1;
      check($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(vecs[i].br));
      check($sformatf("vec%0d busy_mask", i), busy_mask, vecs[i].busy);
      check($sformatf("vec%0d a_stall", i), 32'(a_stall), 32'd0);
      @(posedge clk);
      #1;
      check_rf($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd);
    end

    // Starvation: one queued B entry under continuous A traffic.
    @(negedge clk);
    drive(1'b1, 5'd20, 32'h100, 1'b1, 5'd13, 32'h88888888);
    @(posedge clk);
    #1;
    check_rf("starve push", 1'b1, 5'd20, 32'h100);
`ifdef RF_WRITE_ARB_STARVE_EN
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(20 + i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0);
      #1;
      check($sformatf("starve a%0d a_stall", i), 32'(a_stall), 32'd0);
      check($sformatf("starve a%0d busy", i), busy_mask, 32'h2000);
      @(posedge clk);
      #1;
      check_rf($sformatf("starve a%0d", i), 1'b1, 5'(20 + i), 32'h100 + 32'(i));
    end
    @(negedge clk);
    drive(1'b1, 5'd25, 32'h105, 1'b0, 5'd0, 32'h0);
    #1;
    check("starve force a_stall", 32'(a_stall), 32'd1);
    @(posedge clk);
    #1;
    check_rf("starve force", 1'b1, 5'd13, 32'h88888888);
    @(negedge clk);
    #1;
    check("starve after a_stall", 32'(a_stall), 32'd0);
    check("starve after busy", busy_mask, 32'h0);
    @(posedge clk);
    #1;
    check_rf("starve held a", 1'b1, 5'd25, 32'h105);
`else
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(20 + i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0);
      #1;
      check($sformatf("strict a%0d a_stall", i), 32'(a_stall), 32'd0);
      check($sformatf("strict a%0d busy", i), busy_mask, 32'h2000);
      @(posedge clk);
      #1;
      check_rf($sformatf("strict a%0d", i), 1'b1, 5'(20 + i), 32'h100 + 32'(i));
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check_rf("strict b drain", 1'b1, 5'd13, 32'h88888888);
`endif

    // Mid-stream reset with two queued B entries and a pending write.
    @(negedge clk);
    drive(1'b1, 5'd2, 32'hAAAA0002, 1'b1, 5'd14, 32'hEEEE0014);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd15, 32'hEEEE0015);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("prereset busy", busy_mask, 32'hC000);
    check("prereset b_ready", 32'(b_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_rf("async reset", 1'b0, 5'd0, 32'h0);
    check("async reset b_ready", 32'(b_ready), 32'd1);
    check("async reset busy", busy_mask, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'h99999999);
    #1;
    check("post reset b_ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    #1;
    check("post reset rf_we 0", 32'(rf_we), 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("post reset busy", busy_mask, 32'h10000);
    @(posedge clk);
    #1;
    check_rf("post reset push", 1'b1, 5'd16, 32'h99999999);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post reset idle%0d rf_we", i), 32'(rf_we), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
